// File: rtl/row_feeder.sv
// row_feeder: source-side responder for the row scaler core.
// Maps a destination row to a nearest-neighbour source row, fetches that row
// from the frame-buffer reader into a line buffer, then serves horizontally
// mapped source pixels to the core while it sweeps x_pos.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a row request (wr_req)
// CALC  | latch the mapped source row
// REQ   | src_req pulse, clear the fill counter
// FILL  | write one line-buffer entry per src_valid beat
// DONE  | tran_done pulse, line buffer holds the requested row
// HOLD  | wait for wr_req to drop so one request gives one fetch
module row_feeder #(
  parameter int PIX_WIDTH = 16,
  parameter int FIX_LEN   = 15,
  parameter int FLOAT_LEN = 11,
  parameter int SRC_W     = 640,
  parameter int SRC_H     = 720
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_req,
  input  logic [10:0]          dst_row,
  input  logic [FIX_LEN-1:0]   x_scale,
  input  logic [FIX_LEN-1:0]   y_scale,
  input  logic [10:0]          x_pos,
  output logic [PIX_WIDTH-1:0] input_data,
  output logic                 tran_done,
  output logic                 src_req,
  output logic [10:0]          src_row,
  input  logic [PIX_WIDTH-1:0] src_data,
  input  logic                 src_valid
);

  localparam int IDX_W  = 11;
  localparam int PROD_W = IDX_W + FIX_LEN;
  localparam int CNT_W  = $clog2(SRC_W);

  localparam logic [CNT_W-1:0]  LAST_COL  = CNT_W'(SRC_W - 1);
  localparam logic [PROD_W-1:0] COL_LIMIT = PROD_W'(SRC_W - 1);
  localparam logic [PROD_W-1:0] ROW_LIMIT = PROD_W'(SRC_H - 1);

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    REQ,
    FILL,
    DONE,
    HOLD
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [PIX_WIDTH-1:0] linebuf [SRC_W];

  // Vertical map: zero-based destination row times the step, integer part,
  // clamped to the last source row. Row 0 is treated like row 1.
  logic [IDX_W-1:0]  row_m1;
  logic [PROD_W-1:0] row_prod;
  logic [PROD_W-1:0] row_int;
  logic [IDX_W-1:0]  row_clamped;

  assign row_m1      = (dst_row == '0) ? '0 : dst_row - IDX_W'(1);
  assign row_prod    = PROD_W'(row_m1) * PROD_W'(y_scale);
  assign row_int     = row_prod >> FLOAT_LEN;
  assign row_clamped = (row_int > ROW_LIMIT) ? IDX_W'(SRC_H - 1) : row_int[IDX_W-1:0];

  // Horizontal map, same rule, clamped to the last line-buffer entry.
  logic [IDX_W-1:0]  col_m1;
  logic [PROD_W-1:0] col_prod;
  logic [PROD_W-1:0] col_int;
  logic [CNT_W-1:0]  col_idx;

  assign col_m1   = (x_pos == '0) ? '0 : x_pos - IDX_W'(1);
  assign col_prod = PROD_W'(col_m1) * PROD_W'(x_scale);
  assign col_int  = col_prod >> FLOAT_LEN;
  assign col_idx  = (col_int > COL_LIMIT) ? LAST_COL : col_int[CNT_W-1:0];

  // Buffer writes only happen while filling; stray beats elsewhere are dropped.
  logic buf_we;
  assign buf_we = (state == FILL) && src_valid;

  // Request sequencer with registered pulse outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      src_req   <= 1'b0;
      tran_done <= 1'b0;
      src_row   <= '0;
    end else begin
      src_req   <= 1'b0;
      tran_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            state <= CALC;
          end
        end
        CALC: begin
          src_row <= row_clamped;
          src_req <= 1'b1;
          state   <= REQ;
        end
        REQ: begin
          cnt   <= '0;
          state <= FILL;
        end
        FILL: begin
          if (src_valid) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_COL) begin
              tran_done <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!wr_req) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line-buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      linebuf[cnt] <= src_data;
    end
  end

  // Synchronous read of the mapped column; a same-cycle write returns old data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      input_data <= '0;
    end else begin
      input_data <= linebuf[col_idx];
    end
  end

endmodule

// File: tb/tb_row_feeder.sv
// tb_row_feeder: self-checking bench for row_feeder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_row_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_req = 1'b0;
  logic [10:0] dst_row = '0;
  logic [14:0] x_scale = '0;
  logic [14:0] y_scale = '0;
  logic [10:0] x_pos = '0;
  logic [15:0] input_data;
  logic        tran_done;
  logic        src_req;
  logic [10:0] src_row;
  logic [15:0] src_data = '0;
  logic        src_valid = 1'b0;

  row_feeder dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_req     (wr_req),
    .dst_row    (dst_row),
    .x_scale    (x_scale),
    .y_scale    (y_scale),
    .x_pos      (x_pos),
    .input_data (input_data),
    .tran_done  (tran_done),
    .src_req    (src_req),
    .src_row    (src_row),
    .src_data   (src_data),
    .src_valid  (src_valid)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nmiss = 0;

  // What the line buffer should hold after the most recent complete fill.
  logic [15:0] model_buf [640];

  typedef struct {
    logic [10:0] x;
    logic [14:0] xs;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Nearest-neighbour index: ((idx-1)*scale)/2048, idx 0 treated as 1, clamped.
  function automatic int ref_map(input int idx, input int scale, input int lim);
    int p;
    p = (idx == 0) ? 0 : (idx - 1) * scale;
    p = p / 2048;
    return (p > lim) ? lim : p;
  endfunction

  // Raise wr_req and check the src_req pulse timing and the mapped row.
  // A stray beat during REQ must not land in the buffer.
  task automatic start_req(input int dst, input int ys);
    dst_row = 11'(dst);
    y_scale = 15'(ys);
    wr_req  = 1'b1;
    @(negedge clk);
    check("src_req_early", 32'(src_req), 0);
    @(negedge clk);
    check("src_req_pulse", 32'(src_req), 1);
    check("src_row", 32'(src_row), 32'(ref_map(dst, ys, 719)));
    src_valid = 1'b1;
    src_data  = 16'hBEEF;
    @(negedge clk);
    src_valid = 1'b0;
    check("src_req_width", 32'(src_req), 0);
  endtask

  // Deliver n beats, optionally with idle gaps and random pixel values.
  task automatic fill_beats(input int n, input bit rnd, input bit gaps);
    bit          early;
    bit          v;
    int          k;
    logic [15:0] d;
    early = 1'b0;
    k = 0;
    while (k < n) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_valid = v;
      if (v) begin
        d = rnd ? 16'($urandom) : 16'(k);
        src_data = d;
        model_buf[k] = d;
        k++;
      end else begin
        src_data = 16'($urandom);
      end
      @(negedge clk);
      if (k < n && tran_done) early = 1'b1;
    end
    src_valid = 1'b0;
    check("no_early_done", 32'(early), 0);
  endtask

  task automatic finish_done();
    check("tran_done_pulse", 32'(tran_done), 1);
    @(negedge clk);
    check("tran_done_width", 32'(tran_done), 0);
  endtask

  task automatic full_fetch(input int dst, input int ys, input bit rnd, input bit gaps);
    start_req(dst, ys);
    fill_beats(640, rnd, gaps);
    finish_done();
    wr_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit hold_ok;
    int x;
    int xs;

    tbl[0]  = '{11'd3,    15'd1024,  16'd1};
    tbl[1]  = '{11'd640,  15'd4096,  16'd639};
    tbl[2]  = '{11'd0,    15'd2048,  16'd0};
    tbl[3]  = '{11'd1,    15'd2048,  16'd0};
    tbl[4]  = '{11'd640,  15'd2048,  16'd639};
    tbl[5]  = '{11'd321,  15'd2048,  16'd320};
    tbl[6]  = '{11'd5,    15'd0,     16'd0};
    tbl[7]  = '{11'd640,  15'd1024,  16'd319};
    tbl[8]  = '{11'd100,  15'd3072,  16'd148};
    tbl[9]  = '{11'd2,    15'd32767, 16'd15};
    tbl[10] = '{11'd2047, 15'd32767, 16'd639};
    tbl[11] = '{11'd400,  15'd2560,  16'd498};
    tbl[12] = '{11'd513,  15'd4096,  16'd639};
    tbl[13] = '{11'd320,  15'd4096,  16'd638};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_tran_done", 32'(tran_done), 0);
    check("rst_src_req", 32'(src_req), 0);
    check("rst_src_row", 32'(src_row), 0);
    check("rst_input_data", 32'(input_data), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Unit vertical step, then wr_req held high: no second fetch.
    start_req(5, 2048);
    fill_beats(640, 1'b0, 1'b1);
    finish_done();
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src_valid = 1'b1;
      src_data  = 16'hDEAD;
      @(negedge clk);
      if (src_req) hold_ok = 1'b0;
    end
    src_valid = 1'b0;
    check("no_refetch_while_held", 32'(hold_ok), 1);

    // One low cycle, then a fresh request.
    wr_req = 1'b0;
    @(negedge clk);
    full_fetch(11, 1024, 1'b0, 1'b0);

    // Column map on an index-valued row.
    for (int i = 0; i < 14; i++) begin
      x_pos   = tbl[i].x;
      x_scale = tbl[i].xs;
      @(negedge clk);
      check($sformatf("col_tbl%0d", i), 32'(input_data), 32'(tbl[i].exp));
    end

    x_scale = 15'd2048;
    for (int i = 1; i <= 640; i++) begin
      x_pos = 11'(i);
      @(negedge clk);
      check("col_sweep", 32'(input_data), 32'(i - 1));
    end

    // Clamped row with random pixels, then random column reads.
    full_fetch(720, 4096, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      x  = $urandom_range(0, 2047);
      xs = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4096) : $urandom_range(0, 32767);
      x_pos   = 11'(x);
      x_scale = 15'(xs);
      @(negedge clk);
      check("col_rand", 32'(input_data), 32'(model_buf[ref_map(x, xs, 639)]));
    end

    // dst_row 0 and a few random row maps.
    full_fetch(0, 2048, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      full_fetch($urandom_range(0, 2047), $urandom_range(0, 32767), 1'b1, 1'b1);
    end

    // Abort mid-fill with reset, then a clean refetch while wr_req stays high.
    start_req(300, 2048);
    fill_beats(300, 1'b0, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_tran_done", 32'(tran_done), 0);
    check("abort_src_row", 32'(src_row), 0);
    check("abort_input_data", 32'(input_data), 0);
    rstn = 1'b1;
    start_req(300, 2048);
    fill_beats(640, 1'b1, 1'b1);
    finish_done();
    wr_req = 1'b0;
    @(negedge clk);

    x_scale = 15'd2048;
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(0, 700);
      x_pos = 11'(x);
      @(negedge clk);
      check("col_after_abort", 32'(input_data), 32'(model_buf[ref_map(x, 2048, 639)]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
